// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the N-way instruction cache.
// The optional performance counters are enabled with ICACHE_PERF_CNT_EN.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam int DEFAULT_ADDR_W     = 30;
  localparam int DEFAULT_LINE_WORDS = 4;
  localparam int DEFAULT_SETS       = 4;
  localparam int DEFAULT_WAYS       = 2;

  function automatic int calc_offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int calc_index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_way_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int line_words, input int sets);
    return addr_w - calc_offset_w(line_words) - calc_index_w(sets);
  endfunction

  localparam int OFFSET_W = calc_offset_w(DEFAULT_LINE_WORDS);
  localparam int INDEX_W  = calc_index_w(DEFAULT_SETS);
  localparam int TAG_W    = calc_tag_w(DEFAULT_ADDR_W, DEFAULT_LINE_WORDS, DEFAULT_SETS);

endpackage

// File: rtl/icache_victim_sel.sv
// Replacement choice for one set: lowest-numbered invalid way, otherwise
// the set's round-robin pointer.
module icache_victim_sel #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-1:0]         valid,
  input  logic [$clog2(WAYS)-1:0] rr_ptr,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int WAY_W = $clog2(WAYS);

  // Walk downwards so the lowest invalid way is the last one assigned.
  always_comb begin
    victim = rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/icache_nway.sv
// Read-only N-way set-associative instruction cache with single-line refill.
// Define ICACHE_PERF_CNT_EN to add hit/miss performance counters.
module icache_nway
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 4,
  parameter int WAYS       = 2
) (
  input  logic                                  clk,
  input  logic                                  proc_reset,
  input  logic                                  proc_read,
  input  logic                                  proc_write,
  input  logic                                  proc_flush,
  input  logic [ADDR_W-1:0]                     proc_addr,
  input  logic [31:0]                           proc_wdata,
  output logic                                  proc_stall,
  output logic [31:0]                           proc_rdata,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]  mem_addr,
  input  logic [32*LINE_WORDS-1:0]              mem_rdata,
  input  logic                                  mem_ready,
  output logic [32*LINE_WORDS-1:0]              mem_wdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_hit_cnt,
  output logic [31:0]                           perf_miss_cnt
`endif
);

  localparam int OFFSET_W = calc_offset_w(LINE_WORDS);
  localparam int INDEX_W  = calc_index_w(SETS);
  localparam int TAG_W    = calc_tag_w(ADDR_W, LINE_WORDS, SETS);
  localparam int WAY_W    = calc_way_w(WAYS);

  logic [OFFSET_W-1:0] req_offset;
  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;

  state_t state, state_next;

  logic [WAYS-1:0]              valid_mem [SETS];
  logic [TAG_W-1:0]             tag_mem   [SETS][WAYS];
  logic [LINE_WORDS-1:0][31:0]  data_mem  [SETS][WAYS];
  logic [WAY_W-1:0]             rr_ptr    [SETS];

  logic [TAG_W-1:0]   lat_tag;
  logic [INDEX_W-1:0] lat_index;
  logic [WAY_W-1:0]   lat_way;
  logic               flush_pending;

  logic [WAYS-1:0]  way_match;
  logic [31:0]      hit_word;
  logic             hit;
  logic [WAY_W-1:0] victim_way;
  logic             flush_now;
  logic             start_miss;
  logic             fill_line;
  logic             unused_inputs;

  assign req_offset = proc_addr[OFFSET_W-1:0];
  assign req_index  = proc_addr[OFFSET_W +: INDEX_W];
  assign req_tag    = proc_addr[ADDR_W-1 -: TAG_W];

  assign unused_inputs = proc_write ^ (^proc_wdata);

  always_comb begin
    way_match = '0;
    hit_word  = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_match[w] = valid_mem[req_index][w] && (tag_mem[req_index][w] == req_tag);
      if (way_match[w]) hit_word = hit_word | data_mem[req_index][w][req_offset];
    end
  end

  assign hit        = proc_read && (state == IDLE) && (|way_match);
  assign proc_rdata = hit ? hit_word : 32'h0;

  // A deferred flush from REFILL behaves like a live flush in its IDLE cycle,
  // so no new miss can start while the valids are being wiped.
  assign flush_now  = (state == IDLE) && (proc_flush || flush_pending);
  assign start_miss = (state == IDLE) && !flush_now && proc_read && !hit;
  assign fill_line  = (state == REFILL) && mem_ready;

  assign proc_stall = (state == REFILL) | (proc_read & ~hit) | proc_flush;
  assign mem_read   = (state == REFILL) & ~mem_ready;
  assign mem_addr   = (state == REFILL) ? {lat_tag, lat_index} : proc_addr[ADDR_W-1:OFFSET_W];
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

  icache_victim_sel #(
    .WAYS(WAYS)
  ) u_victim_sel (
    .valid (valid_mem[req_index]),
    .rr_ptr(rr_ptr[req_index]),
    .victim(victim_way)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_miss) state_next = REFILL;
      REFILL:  if (mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state         <= IDLE;
      lat_tag       <= '0;
      lat_index     <= '0;
      lat_way       <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (start_miss) begin
        lat_tag   <= req_tag;
        lat_index <= req_index;
        lat_way   <= victim_way;
      end
      if ((state == REFILL) && proc_flush) flush_pending <= 1'b1;
      else if (flush_now)                  flush_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        rr_ptr[s]    <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w]  <= '0;
          data_mem[s][w] <= '0;
        end
      end
    end else if (flush_now) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        rr_ptr[s]    <= '0;
      end
    end else if (fill_line) begin
      data_mem[lat_index][lat_way]           <= mem_rdata;
      tag_mem[lat_index][lat_way]            <= lat_tag;
      valid_mem[lat_index][lat_way]          <= 1'b1;
      rr_ptr[lat_index]                      <= rr_ptr[lat_index] + WAY_W'(1);
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (hit && !proc_flush) perf_hit_cnt <= perf_hit_cnt + 32'd1;
      if (start_miss)         perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised, read-only, N-way set-associative instruction cache between the fetch stage and the line-wide instruction memory port. It serves word reads in the same cycle on a hit and stalls fetch on a miss while one line is refilled. Compared with the fixed 2-way, 4-set cache it generalises geometry and adds invalid-first/round-robin replacement, a whole-cache flush, and miss-address latching.

## Interface
- ADDR_W, 30: processor word-address width.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥2.
- SETS, 4: number of sets; power of two, ≥2.
- WAYS, 2: associativity; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- proc_reset  in  1  synchronous, active-high reset.
- proc_read  in  1  fetch request.
- proc_write  in  1  ignored; the cache is read-only.
- proc_flush  in  1  invalidate all lines.
- proc_addr  in  ADDR_W  word address: {tag, index, offset}.
- proc_wdata  in  32  ignored.
- proc_stall  out  1  fetch must hold proc_addr/proc_read.
- proc_rdata  out  32  hit word; 0 when there is no hit.
- mem_read  out  1  line refill request.
- mem_write  out  1  tied to 0.
- mem_addr  out  ADDR_W-OFFSET_W  line address {tag, index}.
- mem_rdata  in  32*LINE_WORDS  refill line; word 0 is in the LSBs.
- mem_ready  in  1  refill data valid; one-cycle pulse.
- mem_wdata  out  32*LINE_WORDS  tied to 0.

## Operation
- Address split: OFFSET_W=$clog2(LINE_WORDS), INDEX_W=$clog2(SETS), TAG_W=ADDR_W-OFFSET_W-INDEX_W.
- Hit: proc_read is high in IDLE and exactly one way of the indexed set is valid with a matching tag. proc_rdata is that way's word [offset]. All ways are compared in parallel; duplicate tags cannot arise.
- States:
  - IDLE→REFILL on a read miss while proc_flush is low. On that edge the cache latches tag, index and victim way.
  - REFILL→IDLE when mem_ready is high. On that edge it writes the line, sets the tag and valid bit, and advances the set's round-robin pointer.
  - IDLE→IDLE otherwise.
- Victim: the lowest-numbered invalid way of the set; if all ways are valid, the set's round-robin pointer (log2 WAYS bits, wraps WAYS-1→0).
- proc_stall = (state==REFILL) | (proc_read & ~hit) | proc_flush.
- mem_read = (state==REFILL) & ~mem_ready.
- mem_addr is driven from the latched {tag, index} in REFILL and from proc_addr otherwise.
- Flush:
  - In IDLE: clears every valid bit on the next edge. Round-robin pointers are also reset to 0. Flush has priority over miss detection in the same cycle.
  - In REFILL: sets flush_pending. The refill completes and writes its line, then all valids are cleared on the next edge (IDLE). The refilled line therefore does not survive.
- Reset clears state, valids, tags, data, pointers and flush_pending. Reset mid-REFILL abandons the refill, and mem_read drops on the next cycle.
- Fetch must hold proc_addr stable while proc_stall is high. Changes are tolerated (latched miss), but only the latched line is filled.

## Timing
- Hit: 0-cycle latency, combinational proc_rdata and stall=0.
- Miss: mem_read rises the cycle after the miss is detected and stays high until the mem_ready cycle. The hit is served in the cycle after mem_ready. Total stall = memory latency + 2 cycles.
- Back-to-back misses to different sets each incur the full sequence. There is no hit-under-miss.
- Reset values: proc_stall=proc_read (all lines invalid), proc_rdata=0, mem_read=0, mem_write=0, mem_wdata=0, mem_addr={proc_addr tag, index}.

## Configuration
- ICACHE_PERF_CNT_EN defined: adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - hit increments on each IDLE cycle with proc_read & hit & ~proc_flush.
  - miss increments on each IDLE→REFILL edge.
  - Both wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: no counter ports and no counter logic.

## Structure
- icache_pkg: state enum (IDLE, REFILL) and the width-derivation functions/localparams (OFFSET_W, INDEX_W, TAG_W).
- Sub-module icache_victim_sel: combinational; inputs are the set's valid vector and round-robin pointer; output is the victim way.
- Storage is register arrays [SETS][WAYS]; no SRAM macros.

## Test plan
- Reset, then read addr 0x00 → stall=1, mem_read next cycle with mem_addr=0. Pulse mem_ready after 3 cycles with line {D3,D2,D1,D0} → cycle after: stall=0, rdata=D0. Reading addr 0x01 hits, rdata=D1.
- WAYS=2, SETS=4: fill tags A, B into set 0, then miss tag C → evicts way 0 (pointer=0). Tag D → evicts way 1. Re-reading A misses.
- Fill a set, flush for 1 cycle, then re-read → miss; the victim is way 0 (invalid-first).
- Assert flush mid-REFILL → refill completes, then the same address misses again.
- Assert proc_reset during REFILL with mem_ready held low → mem_read=0 next cycle; a later read misses.
- With ICACHE_PERF_CNT_EN: 1 miss, then 5 hit cycles → perf_miss_cnt=1, perf_hit_cnt=5.
